// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared CPU definitions (MEM-stage access unit state encoding)
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUSY = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : MEM-stage req/ack data-memory controller with stall/timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    mau_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             illegal;
    logic             misaligned;
    logic             start;

    always_comb begin
        access     = MemRead_i ^ MemWrite_i;
        illegal    = MemRead_i & MemWrite_i;
        misaligned = access & ((addr_i[1:0] & WORD_ALIGN_MASK) != 2'b00);
        start      = (state == MAU_IDLE) & access & ~misaligned;
        stall_o    = start | (state == MAU_BUSY);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= MAU_IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            data_o      <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                MAU_IDLE: begin
                    if (start) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_wdata_o <= wdata_i;
                        cnt         <= '0;
                        state       <= MAU_BUSY;
                    end else if (illegal | misaligned) begin
                        err_o <= 1'b1;
                    end
                end
                MAU_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An ack in the final timeout cycle still completes cleanly.
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            data_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        state     <= MAU_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        data_o    <= '0;
                        state     <= MAU_DONE;
                    end
                end
                MAU_DONE: begin
                    cnt   <= '0;
                    state <= MAU_IDLE;
                end
                default: begin
                    state <= MAU_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : directed + randomized check against a transaction model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] data_o;
    logic        err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] data_m = '0;
    logic        err_m  = 1'b0;

    mem_access_unit #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .data_o(data_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat = BUSY cycle in which memory acks (1..TIMEOUT); 0 = memory never acks.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rdat);
        logic acc;
        logic bad;
        acc = rd ^ wr;
        bad = (rd & wr) | (acc & (a[1:0] != 2'b00));
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        mem_ack_i  = 1'b0;
        if (!acc || bad) begin
            @(negedge clk_i);
            chk("noreq_stall", stall_o, 0);
            chk("noreq_req", mem_req_o, 0);
            @(posedge clk_i); #1;
            MemRead_i  = 1'b0;
            MemWrite_i = 1'b0;
            if (bad) err_m = 1'b1;
            chk("noreq_err", err_o, err_m);
            chk("noreq_data", data_o, data_m);
            return;
        end
        @(negedge clk_i);
        chk("detect_stall", stall_o, 1);
        chk("detect_req", mem_req_o, 0);
        @(posedge clk_i); #1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            mem_ack_i   = (k == lat);
            mem_rdata_i = (k == lat) ? rdat : $urandom;
            @(negedge clk_i);
            chk("busy_stall", stall_o, 1);
            chk("busy_req", mem_req_o, 1);
            chk("busy_we", mem_we_o, wr);
            chk("busy_addr", mem_addr_o, {a[31:2], 2'b00});
            chk("busy_wdata", mem_wdata_o, wd);
            chk("busy_data", data_o, data_m);
            chk("busy_err", err_o, err_m);
            @(posedge clk_i); #1;
            if (k == lat) break;
        end
        mem_ack_i = 1'b0;
        if (lat >= 1 && lat <= TIMEOUT) begin
            if (rd) data_m = rdat;
        end else begin
            err_m  = 1'b1;
            data_m = '0;
        end
        @(negedge clk_i);
        chk("done_stall", stall_o, 0);
        chk("done_req", mem_req_o, 0);
        chk("done_data", data_o, data_m);
        chk("done_err", err_o, err_m);
        @(posedge clk_i); #1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        mem_ack_i   = 1'($urandom % 2);
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("idle_stall", stall_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_data", data_o, data_m);
        chk("idle_err", err_o, err_m);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_stall", stall_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
        do_op(1'b0, 1'b1, 32'h20, 32'h12345678, 5, 32'hFFFF0000);
        do_op(1'b1, 1'b0, 32'h44, 32'h0, TIMEOUT, 32'hA5A5A5A5);

        for (int i = 0; i < 20; i++) begin
            logic r;
            r = 1'($urandom % 2);
            do_op(r, ~r, {$urandom, 2'b00} >> 2 << 2, $urandom,
                  int'($urandom_range(1, TIMEOUT)), $urandom);
        end

        do_op(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0);
        do_op(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0);
        do_op(1'b1, 1'b1, 32'h40, 32'h0, 1, 32'h0);

        for (int i = 0; i < 20; i++) begin
            int kind;
            int lat;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            lat  = int'($urandom_range(1, TIMEOUT + 3));
            if (lat > TIMEOUT) lat = 0;
            a = $urandom;
            a[1:0] = (kind == 0) ? 2'(int'($urandom_range(1, 3))) : 2'b00;
            if (kind == 1) do_op(1'b1, 1'b1, a, $urandom, lat, $urandom);
            else if (kind < 6) do_op(1'b1, 1'b0, a, $urandom, lat, $urandom);
            else do_op(1'b0, 1'b1, a, $urandom, lat, $urandom);
        end

        // Reset in the third BUSY cycle of a load that never acks.
        do_op(1'b1, 1'b0, 32'h50, 32'h0, 2, 32'h0BADF00D);
        MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h60; wdata_i = 32'h77;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        #1;
        rst_i = 1'b0; MemRead_i = 1'b0;
        #1;
        err_m = 1'b0; data_m = '0;
        chk("arst_req", mem_req_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_we", mem_we_o, 0);
        chk("arst_addr", mem_addr_o, 0);
        chk("arst_wdata", mem_wdata_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_err", err_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEBABE;
        @(negedge clk_i);
        chk("stray_stall", stall_o, 0);
        chk("stray_req", mem_req_o, 0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        chk("stray_data", data_o, 0);
        chk("stray_err", err_o, 0);
        do_op(1'b1, 1'b0, 32'h70, 32'h0, 3, 32'h13579BDF);
        do_op(1'b0, 1'b1, 32'h74, 32'h2468ACE0, 1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
